two_bit_comp_using_nand: RTL and testbench

- Unsigned magnitude comparator of two WIDTH-bit operands (default 2). Outputs one-hot less / equal / greater flags.
- Compare logic is built only from 2-input NAND primitives, as a MSB-to-LSB cascade of bit slices.
- Flags are registered on the single clock.
- Used as a small datapath compare leaf and a NAND-only gate-mapping exemplar.

---
 rtl/cmp_nand_pkg.sv | 16 +
 rtl/cmp_bit_slice_nand.sv | 49 ++++
 rtl/two_bit_comp_using_nand.sv | 77 +++++++
 tb/tb_two_bit_comp_using_nand.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_nand_pkg.sv
// Shared constants and the NAND2 primitive for the NAND-only magnitude comparator.
// Result codes are ordered {l,e,g}.
package cmp_nand_pkg;

  localparam int CMP_WIDTH_DEFAULT = 2;

  localparam logic [2:0] CMP_LT  = 3'b100;
  localparam logic [2:0] CMP_EQ  = 3'b010;
  localparam logic [2:0] CMP_GT  = 3'b001;
  localparam logic [2:0] CMP_RST = 3'b000;

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

endpackage

// File: rtl/cmp_bit_slice_nand.sv
// One bit of the MSB-to-LSB compare cascade, built only from 2-input NANDs.
// A slice can only set gt/lt while every more significant bit compared equal.
module cmp_bit_slice_nand
  import cmp_nand_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic gt_in,
  input  logic eq_in,
  input  logic lt_in,
  output logic gt_out,
  output logic eq_out,
  output logic lt_out
);

  logic a_n, b_n;
  logic gt_i_n, gt_i, lt_i_n, lt_i;
  logic ab_n, xa, xb, x_ab, eq_i;
  logic gt_in_n, lt_in_n, gt_term_n, lt_term_n, eq_term_n;

  assign a_n    = nand2(a_i, a_i);
  assign b_n    = nand2(b_i, b_i);

  assign gt_i_n = nand2(a_i, b_n);
  assign gt_i   = nand2(gt_i_n, gt_i_n);
  assign lt_i_n = nand2(a_n, b_i);
  assign lt_i   = nand2(lt_i_n, lt_i_n);

  // Classic four-NAND XOR, then inverted to XNOR.
  assign ab_n   = nand2(a_i, b_i);
  assign xa     = nand2(a_i, ab_n);
  assign xb     = nand2(b_i, ab_n);
  assign x_ab   = nand2(xa, xb);
  assign eq_i   = nand2(x_ab, x_ab);

  // OR(x, AND(y,z)) = NAND(~x, NAND(y,z)): the inverter after the AND's NAND
  // cancels against the OR's input inverter.
  assign gt_in_n   = nand2(gt_in, gt_in);
  assign gt_term_n = nand2(eq_in, gt_i);
  assign gt_out    = nand2(gt_in_n, gt_term_n);

  assign lt_in_n   = nand2(lt_in, lt_in);
  assign lt_term_n = nand2(eq_in, lt_i);
  assign lt_out    = nand2(lt_in_n, lt_term_n);

  assign eq_term_n = nand2(eq_in, eq_i);
  assign eq_out    = nand2(eq_term_n, eq_term_n);

endmodule

// File: rtl/two_bit_comp_using_nand.sv
// Registered unsigned magnitude comparator over a chain of NAND-only bit slices.
// Optional CMP_ONEHOT_CHECK_EN adds a sticky err flag for non-one-hot results.
module two_bit_comp_using_nand
  import cmp_nand_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             l,
  output logic             e,
`ifdef CMP_ONEHOT_CHECK_EN
  output logic             err,
`endif
  output logic             g
);

  // Cascade index WIDTH feeds the MSB slice; index 0 is the final result.
  logic [WIDTH:0] gt_c;
  logic [WIDTH:0] eq_c;
  logic [WIDTH:0] lt_c;
  logic [2:0]     flags_next;
  logic [2:0]     flags_reg;

  assign gt_c[WIDTH] = 1'b0;
  assign eq_c[WIDTH] = 1'b1;
  assign lt_c[WIDTH] = 1'b0;

  generate
    for (genvar gi = WIDTH - 1; gi >= 0; gi--) begin : gen_slice
      cmp_bit_slice_nand u_slice (
        .a_i    (a[gi]),
        .b_i    (b[gi]),
        .gt_in  (gt_c[gi+1]),
        .eq_in  (eq_c[gi+1]),
        .lt_in  (lt_c[gi+1]),
        .gt_out (gt_c[gi]),
        .eq_out (eq_c[gi]),
        .lt_out (lt_c[gi])
      );
    end
  endgenerate

  assign flags_next = {lt_c[0], eq_c[0], gt_c[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_reg <= CMP_RST;
    end else begin
      flags_reg <= flags_next;
    end
  end

  assign l = flags_reg[2];
  assign e = flags_reg[1];
  assign g = flags_reg[0];

`ifdef CMP_ONEHOT_CHECK_EN
  logic onehot_ok;
  logic err_reg;

  assign onehot_ok = (flags_next[2] ^ flags_next[1] ^ flags_next[0]) & ~(&flags_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_reg | ~onehot_ok;
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_two_bit_comp_using_nand.sv
// Scoreboard bench for two_bit_comp_using_nand: stimulus pushes expected {l,e,g}
// per cycle, a monitor pops and compares one cycle after the sampling edge.
module tb_two_bit_comp_using_nand;
  import cmp_nand_pkg::*;

  typedef struct {
    logic [2:0] flags;
    logic       err;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] a2, b2;
  logic [3:0] a4, b4;
  logic       l2, e2, g2, l4, e4, g4;
`ifdef CMP_ONEHOT_CHECK_EN
  logic       err2, err4;
`endif

  exp_t q2[$];
  exp_t q4[$];
  int   vectors;
  int   miscompares;

  // Hand-computed {l,e,g} for (a,b), index a*4+b.
  localparam logic [2:0] SWEEP_EXP [16] = '{
    CMP_EQ, CMP_LT, CMP_LT, CMP_LT,
    CMP_GT, CMP_EQ, CMP_LT, CMP_LT,
    CMP_GT, CMP_GT, CMP_EQ, CMP_LT,
    CMP_GT, CMP_GT, CMP_GT, CMP_EQ
  };

  two_bit_comp_using_nand #(.WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .a   (a2),
    .b   (b2),
    .l   (l2),
    .e   (e2),
`ifdef CMP_ONEHOT_CHECK_EN
    .err (err2),
`endif
    .g   (g2)
  );

  two_bit_comp_using_nand #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .a   (a4),
    .b   (b4),
    .l   (l4),
    .e   (e4),
`ifdef CMP_ONEHOT_CHECK_EN
    .err (err4),
`endif
    .g   (g4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive2(input logic r, input logic [1:0] av, input logic [1:0] bv,
                        input logic [2:0] exp_flags, input string nm);
    exp_t t;
    @(negedge clk);
    rst = r;
    a2  = av;
    b2  = bv;
    t.flags = exp_flags;
    t.err   = 1'b0;
    t.name  = nm;
    q2.push_back(t);
  endtask

  task automatic drive4(input logic [3:0] av, input logic [3:0] bv,
                        input logic [2:0] exp_flags, input string nm);
    exp_t t;
    @(negedge clk);
    rst = 1'b0;
    a4  = av;
    b4  = bv;
    t.flags = exp_flags;
    t.err   = 1'b0;
    t.name  = nm;
    q4.push_back(t);
  endtask

  // Monitor: results are valid just after the edge that sampled the vector.
  always @(posedge clk) begin
    exp_t t;
    #1;
    if (q2.size() > 0) begin
      t = q2.pop_front();
      vectors++;
      if ({l2, e2, g2} !== t.flags) begin
        miscompares++;
        $display("FAIL w2 %s: {l,e,g} got %b expected %b", t.name, {l2, e2, g2}, t.flags);
      end
`ifdef CMP_ONEHOT_CHECK_EN
      vectors++;
      if (err2 !== t.err) begin
        miscompares++;
        $display("FAIL w2 %s err: got %b expected %b", t.name, err2, t.err);
      end
`endif
      $display("w2 %-12s a=%0d b=%0d rst=%b -> leg=%b", t.name, a2, b2, rst, {l2, e2, g2});
    end
    if (q4.size() > 0) begin
      t = q4.pop_front();
      vectors++;
      if ({l4, e4, g4} !== t.flags) begin
        miscompares++;
        $display("FAIL w4 %s: {l,e,g} got %b expected %b", t.name, {l4, e4, g4}, t.flags);
      end
`ifdef CMP_ONEHOT_CHECK_EN
      vectors++;
      if (err4 !== t.err) begin
        miscompares++;
        $display("FAIL w4 %s err: got %b expected %b", t.name, err4, t.err);
      end
`endif
      $display("w4 %-12s a=%h b=%h -> leg=%b", t.name, a4, b4, {l4, e4, g4});
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    a2  = 2'd0;
    b2  = 2'd0;
    a4  = 4'h0;
    b4  = 4'h0;
    repeat (2) @(posedge clk);

    // Reset holds flags low even with a>b presented.
    drive2(1'b1, 2'd3, 2'd0, CMP_RST, "rst_hold0");
    drive2(1'b1, 2'd3, 2'd0, CMP_RST, "rst_hold1");
    drive2(1'b0, 2'd3, 2'd0, CMP_GT,  "rst_release");

    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        drive2(1'b0, 2'(ai), 2'(bi), SWEEP_EXP[ai*4+bi], $sformatf("sweep_%0d_%0d", ai, bi));
      end
    end

    drive2(1'b0, 2'b10, 2'b01, CMP_GT, "msb_gt");
    drive2(1'b0, 2'b01, 2'b10, CMP_LT, "msb_lt");

    drive2(1'b0, 2'd1, 2'd1, CMP_EQ,  "mid_pre");
    drive2(1'b1, 2'd0, 2'd3, CMP_RST, "mid_rst");
    drive2(1'b0, 2'd0, 2'd3, CMP_LT,  "mid_release");

    drive4(4'hF, 4'hE, CMP_GT, "w4_f_e");
    drive4(4'h7, 4'h8, CMP_LT, "w4_7_8");
    drive4(4'hA, 4'hA, CMP_EQ, "w4_a_a");
    drive4(4'h0, 4'h0, CMP_EQ, "w4_zero");
    drive4(4'hF, 4'h0, CMP_GT, "w4_max_0");
    drive4(4'h0, 4'hF, CMP_LT, "w4_0_max");

`ifdef CMP_ONEHOT_CHECK_EN
    begin
      exp_t t;
      // Stuck-at-1 on the LSB slice eq_out with a>b yields e=g=1.
      @(negedge clk);
      force dut2.gen_slice[0].u_slice.eq_out = 1'b1;
      rst = 1'b0; a2 = 2'd3; b2 = 2'd0;
      t.flags = 3'b011; t.err = 1'b1; t.name = "fault";
      q2.push_back(t);
      @(negedge clk);
      release dut2.gen_slice[0].u_slice.eq_out;
      a2 = 2'd1; b2 = 2'd2;
      t.flags = CMP_LT; t.err = 1'b1; t.name = "err_sticky0";
      q2.push_back(t);
      @(negedge clk);
      a2 = 2'd2; b2 = 2'd2;
      t.flags = CMP_EQ; t.err = 1'b1; t.name = "err_sticky1";
      q2.push_back(t);
      @(negedge clk);
      rst = 1'b1;
      t.flags = CMP_RST; t.err = 1'b0; t.name = "err_rst";
      q2.push_back(t);
      @(negedge clk);
      rst = 1'b0; a2 = 2'd0; b2 = 2'd0;
      t.flags = CMP_EQ; t.err = 1'b0; t.name = "err_cleared";
      q2.push_back(t);
    end
`endif

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (q2.size() != 0 || q4.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending w2=%0d w4=%0d expected 0", q2.size(), q4.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
